// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-ported word memory among eight cores.
// Each access walks IDLE -> ISSUE -> RESP; bad addresses return a fault pulse instead of rvalid.
module mem_port_arbiter #(
   parameter int          NUM_CORES = 8,
   parameter logic [31:0] BASE      = 32'd16,
   parameter int          DEPTH     = 1024,
   parameter int          IDX_W     = 10
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [NUM_CORES-1:0]   req,
   input  logic [NUM_CORES-1:0]   wr_en,
   input  logic [32*NUM_CORES-1:0] addr,
   input  logic [32*NUM_CORES-1:0] wdata,
   output logic [NUM_CORES-1:0]   grant,
   output logic [NUM_CORES-1:0]   rvalid,
   output logic [NUM_CORES-1:0]   fault,
   output logic [31:0]            rdata,
   output logic                   busy,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [IDX_W-1:0]       mem_index,
   output logic [31:0]            mem_wdata,
   input  logic [31:0]            mem_rdata
);

   localparam int          PTR_W   = $clog2(NUM_CORES);
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   winner;
   logic               lat_bad;
   logic               lat_we;
   logic               resp_rd;

   logic               pick_found;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   cand;
   logic [31:0]        sel_addr;
   logic [31:0]        sel_wdata;
   logic               sel_we;
   logic [31:0]        diff;
   logic               legal;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      // Scan from the farthest offset down so the candidate closest above ptr wins.
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         cand = ptr + PTR_W'(i);
         if (req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
      sel_addr  = addr[32*pick_idx +: 32];
      sel_wdata = wdata[32*pick_idx +: 32];
      sel_we    = wr_en[pick_idx];
      diff      = sel_addr - BASE;
      legal     = (sel_addr >= BASE) && (sel_addr[1:0] == 2'b00) && ((diff >> 2) < DEPTH_W);
   end

   // Read data is only forwarded during the response of a legal read; the memory answers one cycle after mem_en.
   assign rdata = resp_rd ? mem_rdata : 32'h0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         ptr       <= '0;
         winner    <= '0;
         lat_bad   <= 1'b0;
         lat_we    <= 1'b0;
         resp_rd   <= 1'b0;
         grant     <= '0;
         rvalid    <= '0;
         fault     <= '0;
         busy      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_index <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state     <= ISSUE;
                  winner    <= pick_idx;
                  grant     <= NUM_CORES'(1) << pick_idx;
                  busy      <= 1'b1;
                  lat_bad   <= !legal;
                  lat_we    <= sel_we;
                  mem_en    <= legal;
                  mem_we    <= legal && sel_we;
                  mem_index <= legal ? diff[IDX_W+1:2] : '0;
                  mem_wdata <= legal ? sel_wdata : 32'h0;
               end
            end
            ISSUE: begin
               state     <= RESP;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_index <= '0;
               mem_wdata <= '0;
               rvalid    <= lat_bad ? '0 : grant;
               fault     <= lat_bad ? grant : '0;
               resp_rd   <= !lat_bad && !lat_we;
            end
            RESP: begin
               state   <= IDLE;
               ptr     <= winner + PTR_W'(1);
               grant   <= '0;
               busy    <= 1'b0;
               rvalid  <= '0;
               fault   <= '0;
               resp_rd <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue holds the expected
// completion of every issued access and a monitor pops it when rvalid or fault pulses.
module tb_mem_port_arbiter;

   logic         Clk;
   logic         Rst;
   logic [7:0]   req;
   logic [7:0]   wr_en;
   logic [255:0] addr;
   logic [255:0] wdata;
   logic [7:0]   grant;
   logic [7:0]   rvalid;
   logic [7:0]   fault;
   logic [31:0]  rdata;
   logic         busy;
   logic         mem_en;
   logic         mem_we;
   logic [9:0]   mem_index;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;

   typedef struct packed {
      logic [7:0]  oh;
      logic        flt;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .req       (req),
      .wr_en     (wr_en),
      .addr      (addr),
      .wdata     (wdata),
      .grant     (grant),
      .rvalid    (rvalid),
      .fault     (fault),
      .rdata     (rdata),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_index (mem_index),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [31:0] pat(input logic [9:0] i);
      return {16'hC0DE, 6'h00, i};
   endfunction

   // Memory model: synchronous read, data one cycle after mem_en.
   initial mem_rdata = 32'h0;
   always @(posedge Clk) begin
      if (mem_en) mem_rdata <= mem_we ? 32'h0 : pat(mem_index);
      else        mem_rdata <= 32'hBAD0_0000;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Completion monitor.
   always @(negedge Clk) begin
      exp_t e;
      if ((rvalid !== 8'h00) || (fault !== 8'h00)) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'({rvalid, fault}), 32'h0);
         end else begin
            e = sb.pop_front();
            check("resp_rvalid", 32'(rvalid), 32'(e.flt ? 8'h00 : e.oh));
            check("resp_fault",  32'(fault),  32'(e.flt ? e.oh : 8'h00));
            check("resp_rdata",  rdata, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge Clk);
   endtask

   task automatic set_core(input int c, input logic [31:0] a, input logic we, input logic [31:0] d);
      addr[32*c +: 32]  = a;
      wdata[32*c +: 32] = d;
      wr_en[c]          = we;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctl"},   32'({grant, rvalid, fault, busy, mem_en, mem_we}), 32'h0);
      check({tag, "_rdata"}, rdata, 32'h0);
      check({tag, "_index"}, 32'(mem_index), 32'h0);
      check({tag, "_wdata"}, mem_wdata, 32'h0);
   endtask

   // One isolated access by core c; bad is the expected outcome of the address check.
   task automatic do_access(input int c, input logic [31:0] a, input logic we,
                            input logic [31:0] d, input logic bad);
      logic [31:0] diff;
      logic [7:0]  oh;
      exp_t        e;
      diff   = a - 32'd16;
      oh     = 8'(1) << c;
      e.oh   = oh;
      e.flt  = bad;
      e.data = (bad || we) ? 32'h0 : pat(diff[11:2]);
      set_core(c, a, we, d);
      req = oh;
      sb.push_back(e);
      step();  // ISSUE
      check("issue_grant",  32'(grant), 32'(oh));
      check("issue_busy",   32'(busy), 32'h1);
      check("issue_mem_en", 32'(mem_en), 32'(!bad));
      check("issue_mem_we", 32'(mem_we), 32'(!bad && we));
      check("issue_rdata",  rdata, 32'h0);
      if (!bad) begin
         check("issue_index", 32'(mem_index), 32'(diff[11:2]));
         check("issue_wdata", mem_wdata, d);
      end
      step();  // RESP
      check("resp_grant",  32'(grant), 32'(oh));
      check("resp_mem_en", 32'(mem_en), 32'h0);
      req = 8'h00;
      step();  // IDLE
      check("idle_grant", 32'({grant, busy}), 32'h0);
   endtask

   initial begin
      exp_t e;
      Rst   = 1'b1;
      req   = 8'h00;
      wr_en = 8'h00;
      addr  = '0;
      wdata = '0;
      step();
      step();
      check_idle("reset");
      Rst = 1'b0;
      step();
      check_idle("idle_no_req");

      do_access(3, 32'h0000_0018, 1'b0, 32'h1111_2222, 1'b0);  // ptr -> 4
      do_access(5, 32'h0000_0410, 1'b1, 32'hDEAD_BEEF, 1'b0);  // ptr -> 6
      do_access(1, 32'h0000_000C, 1'b0, 32'h0, 1'b1);
      do_access(1, 32'h0000_0012, 1'b0, 32'h0, 1'b1);
      do_access(1, 32'h0000_1010, 1'b0, 32'h0, 1'b1);          // ptr -> 2
      do_access(1, 32'h0000_100C, 1'b0, 32'h0, 1'b0);          // last legal word
      do_access(6, 32'h0000_0020, 1'b0, 32'h0, 1'b0);          // ptr -> 7

      // Fairness after wrap: ptr = 7 with cores 7 and 0 requesting.
      set_core(7, 32'h0000_00B0, 1'b0, 32'h0);
      set_core(0, 32'h0000_00B4, 1'b0, 32'h0);
      e = '{oh: 8'h80, flt: 1'b0, data: pat(10'd40)};
      sb.push_back(e);
      e = '{oh: 8'h01, flt: 1'b0, data: pat(10'd41)};
      sb.push_back(e);
      req = 8'h81;
      step();
      check("wrap_first_grant", 32'(grant), 32'h80);
      step();
      check("wrap_first_resp", 32'(grant), 32'h80);
      req[7] = 1'b0;
      step();
      check("wrap_gap", 32'(grant), 32'h0);
      step();
      check("wrap_second_grant", 32'(grant), 32'h01);
      step();
      check("wrap_second_resp", 32'(grant), 32'h01);
      req = 8'h00;
      step();

      // Reset while a core-6 read is in ISSUE: no completion may follow.
      set_core(6, 32'h0000_0040, 1'b0, 32'h0);
      req = 8'h40;
      step();
      check("abort_issue_grant", 32'(grant), 32'h40);
      check("abort_issue_mem_en", 32'(mem_en), 32'h1);
      Rst = 1'b1;
      step();
      check_idle("abort_reset");

      // All eight cores request continuously: grant order 0..7 then 0.
      for (int c = 0; c < 8; c++) set_core(c, 32'(16 + 4 * (c * 37 + 5)), 1'b0, 32'h0);
      for (int k = 0; k < 9; k++) begin
         e = '{oh: 8'(1) << (k % 8), flt: 1'b0, data: pat(10'((k % 8) * 37 + 5))};
         sb.push_back(e);
      end
      req = 8'hFF;
      Rst = 1'b0;
      for (int k = 0; k < 9; k++) begin
         step();
         check("rr_issue_grant", 32'(grant), 32'(8'(1) << (k % 8)));
         step();
         check("rr_resp_grant", 32'(grant), 32'(8'(1) << (k % 8)));
         if (k == 8) req = 8'h00;
         step();
         check("rr_idle_grant", 32'(grant), 32'h0);
      end
      step();
      check_idle("final_idle");
      check("scoreboard_empty", 32'(sb.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
